// File: rtl/sine_demod_pkg.sv
// Shared constants for the sine-table BPSK demodulator: reference table, sizes and FSM states.
// The table must stay bit-identical to the modulator's copy.
package sine_demod_pkg;

    localparam int SAMPLES_PER_SYM = 52;
    localparam int ACC_W           = 22;
    localparam int IDX_W           = 6;

    typedef enum logic {IDLE, ACQ} state_e;

    // One carrier period, peak 78 at index 13, negative half mirrored.
    localparam logic signed [7:0] SINE_TABLE [SAMPLES_PER_SYM] = '{
        8'sd0,   8'sd9,   8'sd18,  8'sd27,  8'sd36,  8'sd44,  8'sd51,  8'sd58,
        8'sd64,  8'sd69,  8'sd73,  8'sd75,  8'sd77,  8'sd78,  8'sd77,  8'sd75,
        8'sd73,  8'sd69,  8'sd64,  8'sd58,  8'sd51,  8'sd44,  8'sd36,  8'sd27,
        8'sd18,  8'sd9,   8'sd0,   -8'sd9,  -8'sd18, -8'sd27, -8'sd36, -8'sd44,
        -8'sd51, -8'sd58, -8'sd64, -8'sd69, -8'sd73, -8'sd75, -8'sd77, -8'sd78,
        -8'sd77, -8'sd75, -8'sd73, -8'sd69, -8'sd64, -8'sd58, -8'sd51, -8'sd44,
        -8'sd36, -8'sd27, -8'sd18, -8'sd9
    };

endpackage

// File: rtl/sine_ref_rom.sv
// Combinational lookup of the 0-degree reference sine sample for a symbol index.
module sine_ref_rom
    import sine_demod_pkg::*;
(
    input  logic [IDX_W-1:0]  idx_i,
    output logic signed [7:0] ref_o
);

    always_comb begin
        ref_o = '0;
        if (idx_i < IDX_W'(SAMPLES_PER_SYM)) begin
            ref_o = SINE_TABLE[idx_i];
        end
    end

endmodule

// File: rtl/bpsk_sine_demod.sv
// Per-symbol correlator against the reference sine with a hard sign decision.
// Optional erasure flag when compiled with SINE_DEMOD_ERASURE_EN.
module bpsk_sine_demod #(
    parameter int SAMPLES_PER_SYM = sine_demod_pkg::SAMPLES_PER_SYM,
    parameter int ACC_W           = sine_demod_pkg::ACC_W,
    parameter int ERASE_THRESH    = 20000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic signed [7:0]       sample_in,
    input  logic                    sample_valid,
    input  logic                    sync,
    output logic                    data_out,
    output logic                    data_valid,
    output logic signed [ACC_W-1:0] corr_out,
    output logic                    locked,
    output logic                    erasure
);

    import sine_demod_pkg::*;

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d, rom_idx;
    logic signed [ACC_W-1:0] acc_q, acc_d, corr_q, corr_d;
    logic signed [ACC_W-1:0] prod_ext, final_sum;
    logic signed [7:0]       ref_val;
    logic signed [15:0]      prod;
    logic                    data_out_q, data_out_d;
    logic                    data_valid_q, data_valid_d;
    logic                    erasure_q, erasure_d;
    logic                    accept_sync, last_sample, is_weak;

    assign accept_sync = sample_valid && sync;
    assign last_sample = (idx_q == IDX_W'(SAMPLES_PER_SYM - 1));
    // A sync sample is always index 0, whatever the running counter says.
    assign rom_idx     = accept_sync ? '0 : idx_q;

    sine_ref_rom u_ref_rom (
        .idx_i (rom_idx),
        .ref_o (ref_val)
    );

    assign prod      = sample_in * ref_val;
    assign prod_ext  = {{(ACC_W - 16){prod[15]}}, prod};
    assign final_sum = acc_q + prod_ext;

`ifdef SINE_DEMOD_ERASURE_EN
    logic [ACC_W-1:0] final_abs;
    assign final_abs = final_sum[ACC_W-1] ? -final_sum : final_sum;
    assign is_weak   = (final_abs < ACC_W'(ERASE_THRESH));
`else
    assign is_weak = 1'b0;
    // Threshold only matters when the erasure comparator is compiled in.
    if (ERASE_THRESH < 0) begin : g_thresh_unused
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept_sync) state_d = ACQ;
            ACQ:     state_d = ACQ;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        locked = (state_q == ACQ);
    end

    always_comb begin
        idx_d        = idx_q;
        acc_d        = acc_q;
        corr_d       = corr_q;
        data_out_d   = data_out_q;
        erasure_d    = erasure_q;
        data_valid_d = 1'b0;
        if (accept_sync) begin
            // Sync restarts the symbol even if this would have been the last sample.
            acc_d = prod_ext;
            idx_d = IDX_W'(1);
        end else if (sample_valid && state_q == ACQ) begin
            if (last_sample) begin
                corr_d       = final_sum;
                data_out_d   = ~final_sum[ACC_W-1];
                erasure_d    = is_weak;
                data_valid_d = 1'b1;
                acc_d        = '0;
                idx_d        = '0;
            end else begin
                acc_d = final_sum;
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q        <= '0;
            acc_q        <= '0;
            corr_q       <= '0;
            data_out_q   <= 1'b0;
            data_valid_q <= 1'b0;
            erasure_q    <= 1'b0;
        end else begin
            idx_q        <= idx_d;
            acc_q        <= acc_d;
            corr_q       <= corr_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            erasure_q    <= erasure_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign corr_out   = corr_q;
    assign erasure    = erasure_q;

endmodule

// File: tb/tb_bpsk_sine_demod.sv
// Directed bench for bpsk_sine_demod: full symbols, back-to-back, gaps, resync and reset.
module tb_bpsk_sine_demod;

    localparam int CORR_FULL = 156452;
`ifdef SINE_DEMOD_ERASURE_EN
    localparam int ERA_ZERO = 1;
`else
    localparam int ERA_ZERO = 0;
`endif

    localparam logic signed [7:0] TB_REF [52] = '{
        8'sd0,   8'sd9,   8'sd18,  8'sd27,  8'sd36,  8'sd44,  8'sd51,  8'sd58,
        8'sd64,  8'sd69,  8'sd73,  8'sd75,  8'sd77,  8'sd78,  8'sd77,  8'sd75,
        8'sd73,  8'sd69,  8'sd64,  8'sd58,  8'sd51,  8'sd44,  8'sd36,  8'sd27,
        8'sd18,  8'sd9,   8'sd0,   -8'sd9,  -8'sd18, -8'sd27, -8'sd36, -8'sd44,
        -8'sd51, -8'sd58, -8'sd64, -8'sd69, -8'sd73, -8'sd75, -8'sd77, -8'sd78,
        -8'sd77, -8'sd75, -8'sd73, -8'sd69, -8'sd64, -8'sd58, -8'sd51, -8'sd44,
        -8'sd36, -8'sd27, -8'sd18, -8'sd9
    };

    logic               clk = 1'b0;
    logic               reset;
    logic signed [7:0]  sample_in;
    logic               sample_valid;
    logic               sync;
    logic               data_out;
    logic               data_valid;
    logic signed [21:0] corr_out;
    logic               locked;
    logic               erasure;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int first_cyc, last_cyc;

    int p_bit[$];
    int p_corr[$];
    int p_era[$];
    int p_cyc[$];

    bpsk_sine_demod u_dut (
        .clk          (clk),
        .reset        (reset),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sync         (sync),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .corr_out     (corr_out),
        .locked       (locked),
        .erasure      (erasure)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (data_valid) begin
            p_bit.push_back(int'(data_out));
            p_corr.push_back(int'(corr_out));
            p_era.push_back(int'(erasure));
            p_cyc.push_back(cyc);
        end
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_pulses();
        p_bit.delete();
        p_corr.delete();
        p_era.delete();
        p_cyc.delete();
    endtask

    task automatic step(input logic signed [7:0] s, input logic v, input logic sy);
        sample_in    = s;
        sample_valid = v;
        sync         = sy;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(8'sd0, 1'b0, 1'b0);
    endtask

    // Samples i0..i0+n-1 of a symbol whose carrier starts at table index phase.
    task automatic send_symbol(input int phase, input bit sync_first, input int i0,
                               input int n, input int scale);
        logic signed [7:0] s;
        for (int i = i0; i < i0 + n; i++) begin
            s = (scale == 0) ? 8'sd0 : TB_REF[(phase + i) % 52];
            step(s, 1'b1, sync_first && (i == 0));
            if (i == i0) first_cyc = cyc;
            last_cyc = cyc;
        end
        sample_valid = 1'b0;
        sync         = 1'b0;
    endtask

    task automatic check_pulse(input string tag, input int k, input int exp_bit,
                               input int exp_corr, input int exp_era);
        if (k >= p_bit.size()) begin
            check_eq({tag, "_present"}, p_bit.size(), k + 1);
        end else begin
            check_eq({tag, "_bit"}, p_bit[k], exp_bit);
            check_eq({tag, "_corr"}, p_corr[k], exp_corr);
            check_eq({tag, "_erasure"}, p_era[k], exp_era);
        end
    endtask

    initial begin
        int sym_start;
        reset        = 1'b1;
        sample_in    = 8'sd0;
        sample_valid = 1'b0;
        sync         = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_data_valid", int'(data_valid), 0);
        check_eq("rst_data_out", int'(data_out), 0);
        check_eq("rst_corr_out", int'(corr_out), 0);
        check_eq("rst_locked", int'(locked), 0);
        check_eq("rst_erasure", int'(erasure), 0);
        reset = 1'b0;

        // Unsynced samples in IDLE are ignored.
        clear_pulses();
        send_symbol(0, 1'b0, 0, 20, 1);
        idle(2);
        check_eq("idle_no_pulse", p_bit.size(), 0);
        check_eq("idle_locked", int'(locked), 0);

        // Phase 0 symbol.
        clear_pulses();
        send_symbol(0, 1'b1, 0, 1, 1);
        check_eq("lock_rise", int'(locked), 1);
        send_symbol(0, 1'b0, 1, 51, 1);
        idle(3);
        check_eq("sym0_count", p_bit.size(), 1);
        check_pulse("sym0", 0, 1, CORR_FULL, 0);
        if (p_cyc.size() > 0) check_eq("sym0_latency", p_cyc[0], last_cyc);
        check_eq("sym0_hold_corr", int'(corr_out), CORR_FULL);

        // 180-degree symbol.
        clear_pulses();
        send_symbol(26, 1'b1, 0, 52, 1);
        idle(3);
        check_eq("sym180_count", p_bit.size(), 1);
        check_pulse("sym180", 0, 0, -CORR_FULL, 0);

        // Back-to-back symbols, sync only on the first.
        clear_pulses();
        send_symbol(0, 1'b1, 0, 52, 1);
        send_symbol(26, 1'b0, 0, 52, 1);
        idle(3);
        check_eq("b2b_count", p_bit.size(), 2);
        check_pulse("b2b_first", 0, 1, CORR_FULL, 0);
        check_pulse("b2b_second", 1, 0, -CORR_FULL, 0);
        if (p_cyc.size() == 2) check_eq("b2b_spacing", p_cyc[1] - p_cyc[0], 52);

        // Ten-cycle gap mid-symbol.
        clear_pulses();
        send_symbol(0, 1'b1, 0, 20, 1);
        sym_start = first_cyc;
        idle(10);
        send_symbol(0, 1'b0, 20, 32, 1);
        idle(3);
        check_eq("gap_count", p_bit.size(), 1);
        check_pulse("gap", 0, 1, CORR_FULL, 0);
        if (p_cyc.size() > 0) check_eq("gap_latency", p_cyc[0] - sym_start, 61);

        // All-zero symbol: tie decides 1.
        clear_pulses();
        send_symbol(0, 1'b1, 0, 52, 0);
        idle(3);
        check_eq("zero_count", p_bit.size(), 1);
        check_pulse("zero", 0, 1, 0, ERA_ZERO);

        // Resync at index 30 discards the partial symbol.
        clear_pulses();
        send_symbol(26, 1'b1, 0, 30, 1);
        send_symbol(0, 1'b1, 0, 52, 1);
        idle(3);
        check_eq("resync30_count", p_bit.size(), 1);
        check_pulse("resync30", 0, 1, CORR_FULL, 0);

        // Sync lands on what would have been index 51: sync wins.
        clear_pulses();
        send_symbol(26, 1'b1, 0, 51, 1);
        send_symbol(0, 1'b1, 0, 52, 1);
        idle(3);
        check_eq("resync51_count", p_bit.size(), 1);
        check_pulse("resync51", 0, 1, CORR_FULL, 0);

        // Reset at index 30, overriding a simultaneous sync.
        clear_pulses();
        send_symbol(0, 1'b1, 0, 30, 1);
        reset = 1'b1;
        step(8'sd50, 1'b1, 1'b1);
        reset = 1'b0;
        step(8'sd0, 1'b0, 1'b0);
        check_eq("rst30_locked", int'(locked), 0);
        check_eq("rst30_corr", int'(corr_out), 0);
        check_eq("rst30_data_out", int'(data_out), 0);
        send_symbol(0, 1'b0, 0, 40, 1);
        idle(2);
        check_eq("rst30_idle_pulses", p_bit.size(), 0);
        check_eq("rst30_idle_locked", int'(locked), 0);
        send_symbol(26, 1'b1, 0, 52, 1);
        idle(3);
        check_eq("rst30_count", p_bit.size(), 1);
        check_pulse("rst30_sym", 0, 0, -CORR_FULL, 0);
        check_eq("rst30_relock", int'(locked), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
